// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmitter among N byte-stream
// requesters. A granted requester keeps the transmitter until its last byte or a stall timeout.
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int GAP_MAX = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           uart_start,
  output logic [7:0]     uart_data,
  input  logic           uart_txe,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           abort
);

  // state | meaning
  // IDLE  | no owner; arbitrate round-robin from rr_ptr among valid requesters
  // SEND  | owner granted; a byte moves when its valid and uart_txe are both high
  // HOLD  | one-cycle gap after each non-last byte while the transmitter drops txe

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     grant_nxt;
  logic [IDX_W-1:0] g_idx, g_idx_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             abort_nxt;

  logic             found;
  logic [IDX_W-1:0] pick;
  int               d;
  int               best_d;
  logic             g_valid;
  logic             g_last;
  logic             xfer;

  assign g_valid = req_valid[g_idx];
  assign g_last  = req_last[g_idx];
  assign xfer    = (state == SEND) && g_valid && uart_txe;
  assign busy    = |grant;

  // Closest valid requester at or after rr_ptr, measured circularly.
  always_comb begin : arb
    found  = |req_valid;
    pick   = '0;
    d      = 0;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(rr_ptr)) % N;
      if (req_valid[i] && (d < best_d)) begin
        best_d = d;
        pick   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      g_idx   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      abort   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      g_idx   <= g_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      gap_cnt <= gap_cnt_nxt;
      abort   <= abort_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt   = state;
    grant_nxt   = grant;
    g_idx_nxt   = g_idx;
    rr_ptr_nxt  = rr_ptr;
    gap_cnt_nxt = gap_cnt;
    abort_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = SEND;
          grant_nxt   = N'(1) << pick;
          g_idx_nxt   = pick;
          rr_ptr_nxt  = (int'(pick) == N - 1) ? '0 : pick + IDX_W'(1);
          gap_cnt_nxt = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          gap_cnt_nxt = '0;
          if (g_last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end else begin
            state_nxt = HOLD;
          end
        end else if (uart_txe) begin
          // The increment that would land on GAP_MAX is the abort itself.
          if (gap_cnt == CNT_W'(GAP_MAX - 1)) begin
            abort_nxt   = 1'b1;
            state_nxt   = IDLE;
            grant_nxt   = '0;
            gap_cnt_nxt = '0;
          end else begin
            gap_cnt_nxt = gap_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        state_nxt = SEND;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_comb begin : outputs
    req_ready  = '0;
    uart_start = 1'b0;
    uart_data  = 8'h00;
    if ((state == SEND) && uart_txe) begin
      req_ready  = grant;
      uart_start = g_valid;
    end
    if ((state == SEND) || (state == HOLD)) begin
      uart_data = req_data[{g_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: lane drivers and a transmitter model feed the DUT,
// a scoreboard of expected bytes is checked by an independent monitor on uart_start.
module tb_uart_tx_arbiter;
  localparam int N       = 3;
  localparam int GAP_MAX = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           uart_start;
  logic [7:0]     uart_data;
  logic           uart_txe;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .GAP_MAX(GAP_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_start(uart_start), .uart_data(uart_data), .uart_txe(uart_txe),
    .grant(grant), .busy(busy), .abort(abort)
  );

  typedef struct packed { logic [7:0] gap; logic last; logic [7:0] data; } entry_t;
  typedef struct packed { logic [7:0] lane; logic last; logic [7:0] data; } exp_t;
  typedef entry_t q_t[$];

  q_t   lq[N];
  int   gapc[N];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   txe_dmin = 1;
  int   txe_dmax = 1;
  int   txe_busy = 0;
  int   n_start = 0;
  int   n_hs = 0;
  int   n_abort = 0;
  int   idle_txe = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lanes_pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += lq[i].size();
    return s;
  endfunction

  // Lane drivers and transmitter model; all input changes land 1 time unit after posedge.
  initial begin : driver
    logic [N-1:0] fire;
    logic         start_s;
    uart_txe  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) gapc[i] = 0;
    forever begin
      @(negedge clk);
      fire    = req_valid & req_ready;
      start_s = uart_start;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gapc[i] > 0) gapc[i]--;
        if (fire[i] && lq[i].size() > 0) begin
          void'(lq[i].pop_front());
          if (lq[i].size() > 0) gapc[i] = int'(lq[i][0].gap);
        end
        if (lq[i].size() == 0) gapc[i] = 0;
        if (lq[i].size() > 0 && gapc[i] == 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = lq[i][0].data;
          req_last[i]        = lq[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      if (start_s && txe_dmax > 0) begin
        uart_txe = 1'b0;
        txe_busy = $urandom_range(txe_dmax, txe_dmin);
      end else if (txe_busy > 0) begin
        txe_busy--;
        if (txe_busy == 0) uart_txe = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t         e;
    logic         prev_start = 1'b0;
    logic         prev_last = 1'b0;
    logic         prev_idle_valid = 1'b0;
    logic         prev_rst = 1'b1;
    logic [N-1:0] prev_valid = '0;
    forever begin
      @(negedge clk);
      if (!rst && !prev_rst) begin
        if (prev_idle_valid) begin
          check("grant_onehot_after_arb", int'($onehot(grant)), 1);
          check("grant_was_valid", int'(|(grant & prev_valid)), 1);
        end
        if (prev_start && prev_last) check("idle_after_last", int'({busy, grant}), 0);
        if (prev_start) check("hold_no_back_to_back_start", int'(uart_start), 0);
      end
      if (abort) begin
        n_abort++;
        check("abort_idle_cycles", idle_txe, GAP_MAX);
      end
      if (|(req_valid & req_ready)) n_hs++;
      if (uart_start) begin
        n_start++;
        check("start_with_txe", int'(uart_txe), 1);
        check("ready_eq_grant", int'(req_ready), int'(grant));
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: data 0x%0h, nothing expected", uart_data);
        end else begin
          e = sb.pop_front();
          check("uart_data", int'(uart_data), int'(e.data));
          check("start_grant", int'(grant), 1 << e.lane);
          check("start_last", int'(|(req_last & grant)), int'(e.last));
        end
      end
      if (grant == '0 || uart_start) idle_txe = 0;
      else if (uart_txe && !(|(req_valid & grant))) idle_txe++;
      prev_start      = uart_start && !rst;
      prev_last       = |(req_last & grant);
      prev_idle_valid = (grant == '0) && (|req_valid) && !rst;
      prev_valid      = req_valid;
      prev_rst        = rst;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int lane, input int gap, input bit last, input logic [7:0] data);
    entry_t e;
    e.gap  = 8'(gap);
    e.last = last;
    e.data = data;
    lq[lane].push_back(e);
  endtask

  task automatic push_exp(input int lane, input bit last, input logic [7:0] data);
    exp_t x;
    x.lane = 8'(lane);
    x.last = last;
    x.data = data;
    sb.push_back(x);
  endtask

  // Reference order: whole packets, round-robin over lanes that still hold packets, from lane 0.
  task automatic plan_rr();
    q_t     cp[N];
    entry_t e;
    int     ptr = 0;
    int     left = 0;
    int     ln;
    bit     done;
    for (int i = 0; i < N; i++) begin
      cp[i] = lq[i];
      left += cp[i].size();
    end
    while (left > 0) begin
      ln = -1;
      for (int k = 0; k < N; k++)
        if (ln < 0 && cp[(ptr + k) % N].size() > 0) ln = (ptr + k) % N;
      done = 1'b0;
      while (!done && cp[ln].size() > 0) begin
        e = cp[ln].pop_front();
        push_exp(ln, e.last, e.data);
        left--;
        done = e.last;
      end
      ptr = (ln + 1) % N;
    end
  endtask

  task automatic rand_load(input int max_pkts);
    int npk;
    int len;
    for (int l = 0; l < N; l++) begin
      npk = $urandom_range(max_pkts, 0);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++)
          push_byte(l, (b == 0) ? 0 : $urandom_range(3, 0), b == len - 1, 8'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) lq[i].delete();
    sb.delete();
    cycles(2);
    rst = 1'b0;
    cycles(2);
    n_start = 0;
    n_hs    = 0;
    n_abort = 0;
  endtask

  task automatic finish_test(input string name, input int budget, input int exp_aborts);
    int t = 0;
    while ((sb.size() > 0 || lanes_pending() > 0 || busy) && t < budget) begin
      cycles(1);
      t++;
    end
    check({name, "_completed"}, int'(t < budget), 1);
    cycles(3);
    check({name, "_starts_eq_handshakes"}, n_start, n_hs);
    check({name, "_aborts"}, n_abort, exp_aborts);
    check({name, "_left_in_scoreboard"}, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    rst = 1'b1;
    cycles(3);
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_abort", int'(abort), 0);
    check("reset_ready", int'(req_ready), 0);
    check("reset_start", int'(uart_start), 0);
    check("reset_data", int'(uart_data), 0);
    rst = 1'b0;
    cycles(2);

    // "Hi\n" on lane 0 with a slow transmitter
    do_reset();
    txe_dmin = 10; txe_dmax = 10;
    push_byte(0, 0, 0, 8'h48); push_byte(0, 0, 0, 8'h69); push_byte(0, 0, 1, 8'h0A);
    plan_rr();
    cycles(1);
    check("t1_valid_up", int'(req_valid), 1);
    check("t1_no_grant_same_cycle", int'(grant), 0);
    cycles(1);
    check("t1_grant_next_cycle", int'(grant), 1);
    finish_test("t1", 200, 0);
    check("t1_start_count", n_start, 3);

    // two lanes, two rounds of 2-byte packets
    do_reset();
    txe_dmin = 1; txe_dmax = 4;
    for (int r = 0; r < 2; r++) begin
      push_byte(0, 0, 0, 8'hAA); push_byte(0, 0, 1, 8'hAB);
      push_byte(1, 0, 0, 8'hBB); push_byte(1, 0, 1, 8'hBC);
    end
    plan_rr();
    finish_test("t2", 300, 0);

    // single-byte packet on lane 1
    do_reset();
    txe_dmin = 2; txe_dmax = 2;
    push_byte(1, 0, 1, 8'h21);
    plan_rr();
    cycles(2);
    check("t3_grant_lane1", int'(grant), 2);
    finish_test("t3", 50, 0);

    // stall timeout on lane 0, lane 1 served, lane 0 resumes as a fresh packet
    do_reset();
    txe_dmin = 3; txe_dmax = 3;
    push_byte(0, 0, 0, 8'h31); push_byte(0, 30, 1, 8'h33);
    push_byte(1, 0, 1, 8'h32);
    push_exp(0, 0, 8'h31); push_exp(1, 1, 8'h32); push_exp(0, 1, 8'h33);
    finish_test("t4", 300, 1);

    // transmitter always ready
    do_reset();
    txe_dmin = 0; txe_dmax = 0;
    rand_load(3);
    plan_rr();
    finish_test("t5", 2000, 0);

    // reset in the middle of a 4-byte packet on lane 1, then arbitration restarts at lane 0
    do_reset();
    txe_dmin = 3; txe_dmax = 3;
    push_byte(1, 0, 0, 8'h41); push_byte(1, 0, 0, 8'h42);
    push_byte(1, 0, 0, 8'h43); push_byte(1, 0, 1, 8'h44);
    plan_rr();
    t = 0;
    while (n_start < 1 && t < 50) begin cycles(1); t++; end
    check("t6_first_byte_seen", int'(t < 50), 1);
    cycles(1);
    check("t6_busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", int'(grant), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_ready", int'(req_ready), 0);
    check("t6_rst_start", int'(uart_start), 0);
    for (int i = 0; i < N; i++) lq[i].delete();
    sb.delete();
    cycles(1);
    rst = 1'b0;
    cycles(1);
    n_start = 0; n_hs = 0; n_abort = 0;
    push_byte(2, 0, 1, 8'h52);
    push_byte(0, 0, 1, 8'h50);
    plan_rr();
    finish_test("t6", 100, 0);

    // randomized packets with a randomly paced transmitter
    for (int r = 0; r < 4; r++) begin
      do_reset();
      txe_dmin = 1; txe_dmax = 5;
      rand_load(3);
      plan_rr();
      finish_test("rand", 3000, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
